// File: rtl/gpu_blit_sequencer_if.sv
// Bus bundle for the blit command front-end: CPU command port, position-generator
// handoff, address-stage config, pixel completion and status.
interface gpu_blit_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_src_base;
    logic [15:0] cmd_src_width;
    logic [15:0] cmd_x;
    logic [15:0] cmd_y;
    logic [15:0] cmd_width;
    logic [15:0] cmd_height;
    logic        gen_valid;
    logic        gen_ready;
    logic [15:0] gen_start_x;
    logic [15:0] gen_start_y;
    logic [15:0] gen_width;
    logic [15:0] gen_height;
    logic [31:0] cfg_base_address;
    logic [15:0] cfg_image_width;
    logic        px_done;
    logic        busy;
    logic        irq;
    logic        err;
    logic        err_clear;

    modport slave (
        input  cmd_valid, cmd_src_base, cmd_src_width, cmd_x, cmd_y, cmd_width, cmd_height,
        input  gen_ready, px_done, err_clear,
        output cmd_ready, gen_valid, gen_start_x, gen_start_y, gen_width, gen_height,
        output cfg_base_address, cfg_image_width, busy, irq, err
    );

    modport master (
        output cmd_valid, cmd_src_base, cmd_src_width, cmd_x, cmd_y, cmd_width, cmd_height,
        output gen_ready, px_done, err_clear,
        input  cmd_ready, gen_valid, gen_start_x, gen_start_y, gen_width, gen_height,
        input  cfg_base_address, cfg_image_width, busy, irq, err
    );
endinterface

// File: rtl/gpu_blit_sequencer.sv
// Blit command front-end: queues CPU commands, issues one rectangle at a time to the
// position generator, holds source config while it runs and counts pixels to completion.
module gpu_blit_sequencer #(
    parameter int unsigned CMD_DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    gpu_blit_sequencer_if.slave bus
);
    localparam int unsigned AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(CMD_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] base;
        logic [15:0] pitch;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] w;
        logic [15:0] h;
    } cmd_t;

    state_t        state_q, state_d;
    cmd_t          fifo_q [CMD_DEPTH];
    cmd_t          fifo_d [CMD_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    cmd_t          cur_q, cur_d;
    logic [31:0]   total_q, total_d, pix_q, pix_d;
    logic          irq_q, irq_d, err_q, err_d;

    cmd_t          head, in_cmd;
    logic          full, empty, push, pop, head_zero, done;

    // Pop is held off during the irq cycle so blits are separated by one idle cycle.
    always_comb begin
        in_cmd    = {bus.cmd_src_base, bus.cmd_src_width, bus.cmd_x, bus.cmd_y,
                     bus.cmd_width, bus.cmd_height};
        head      = fifo_q[rd_ptr_q];
        full      = (cnt_q == FULL_CNT);
        empty     = (cnt_q == '0);
        push      = bus.cmd_valid && !full;
        pop       = (state_q == IDLE) && !empty && !irq_q;
        head_zero = (head.w == '0) || (head.h == '0);
        done      = (state_q == DRAIN) && ((pix_q + 32'(bus.px_done)) == total_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            cur_q    <= '0;
            total_q  <= '0;
            pix_q    <= '0;
            irq_q    <= 1'b0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < CMD_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            total_q  <= total_d;
            pix_q    <= pix_d;
            irq_q    <= irq_d;
            err_q    <= err_d;
            fifo_q   <= fifo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop && !head_zero) state_d = ISSUE;
            ISSUE:   if (bus.gen_ready)     state_d = DRAIN;
            DRAIN:   if (done)              state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            fifo_d[wr_ptr_q] = in_cmd;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Zero-area heads are popped and discarded without touching the latched command.
    always_comb begin
        cur_d   = cur_q;
        total_d = total_q;
        pix_d   = pix_q;
        irq_d   = done;
        err_d   = err_q;
        if (pop && !head_zero) begin
            cur_d   = head;
            total_d = 32'(head.w) * 32'(head.h);
            pix_d   = '0;
        end else if ((state_q != IDLE) && bus.px_done) begin
            pix_d = pix_q + 32'd1;
        end
        if ((state_q == IDLE) && bus.px_done) err_d = 1'b1;
        else if (bus.err_clear)               err_d = 1'b0;
    end

    always_comb begin
        bus.cmd_ready        = !full;
        bus.gen_valid        = (state_q == ISSUE);
        bus.busy             = (state_q != IDLE);
        bus.gen_start_x      = cur_q.x;
        bus.gen_start_y      = cur_q.y;
        bus.gen_width        = cur_q.w;
        bus.gen_height       = cur_q.h;
        bus.cfg_base_address = cur_q.base;
        bus.cfg_image_width  = cur_q.pitch;
        bus.irq              = irq_q;
        bus.err              = err_q;
    end
endmodule

// File: tb/tb_gpu_blit_sequencer.sv
// Scoreboard bench for gpu_blit_sequencer: stimulus queues expected rectangles and
// completions; a negedge monitor checks every generator offer and every irq.
module tb_gpu_blit_sequencer;
    typedef struct packed {
        logic [31:0] base;
        logic [15:0] pitch;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] w;
        logic [15:0] h;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    cmd_t gen_exp[$];
    int   irq_exp[$];
    cmd_t last_cmd = '0;
    cmd_t e;
    int   sz[5] = '{2, 3, 3, 1, 4};

    gpu_blit_sequencer_if bus();

    gpu_blit_sequencer #(.CMD_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [31:0] b, input logic [15:0] p, input logic [15:0] x,
                                input logic [15:0] y, input logic [15:0] w, input logic [15:0] h);
        mk = {b, p, x, y, w, h};
    endfunction

    task automatic push(input cmd_t c);
        int k = 0;
        {bus.cmd_src_base, bus.cmd_src_width, bus.cmd_x, bus.cmd_y,
         bus.cmd_width, bus.cmd_height} = c;
        bus.cmd_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.cmd_ready) break;
            k++;
            if (k > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL push_timeout: cmd_ready=0 expected 1 within 200 cycles");
                bus.cmd_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        if (c.w != 16'd0 && c.h != 16'd0) begin
            gen_exp.push_back(c);
            irq_exp.push_back(1);
        end
    endtask

    task automatic px(input int n);
        repeat (n) begin
            bus.px_done = 1'b1;
            @(posedge clk); #1;
        end
        bus.px_done = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (!(bus.busy && !bus.gen_valid)) begin
            @(negedge clk);
            k++;
            if (k > 100) begin
                n_cmp++;
                n_err++;
                $display("FAIL wait_drain: DRAIN not reached, busy=%b gen_valid=%b", bus.busy, bus.gen_valid);
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_gen_valid();
        int k = 0;
        while (!bus.gen_valid) begin
            @(negedge clk);
            k++;
            if (k > 100) begin
                n_cmp++;
                n_err++;
                $display("FAIL wait_gen_valid: gen_valid=0 expected 1 within 100 cycles");
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    // Monitor: every generator offer must match the oldest queued rectangle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.gen_valid) begin
                if (gen_exp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL gen_unexpected: gen_valid=1 required 0 (no command pending)");
                end else begin
                    e = gen_exp[0];
                    chk("gen_start_x", 32'(bus.gen_start_x), 32'(e.x));
                    chk("gen_start_y", 32'(bus.gen_start_y), 32'(e.y));
                    chk("gen_width", 32'(bus.gen_width), 32'(e.w));
                    chk("gen_height", 32'(bus.gen_height), 32'(e.h));
                    chk("cfg_base_issue", bus.cfg_base_address, e.base);
                    chk("cfg_pitch_issue", 32'(bus.cfg_image_width), 32'(e.pitch));
                    chk1("busy_issue", bus.busy, 1'b1);
                    if (bus.gen_ready) last_cmd = gen_exp.pop_front();
                end
            end else if (bus.busy) begin
                chk("cfg_base_drain", bus.cfg_base_address, last_cmd.base);
                chk("cfg_pitch_drain", 32'(bus.cfg_image_width), 32'(last_cmd.pitch));
                chk("gen_width_drain", 32'(bus.gen_width), 32'(last_cmd.w));
            end
            if (bus.irq) begin
                if (irq_exp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL irq_unexpected: irq=1 required 0 (no blit outstanding)");
                end else begin
                    void'(irq_exp.pop_front());
                    chk1("irq_busy_low", bus.busy, 1'b0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd_valid     = 1'b0;
        bus.cmd_src_base  = '0;
        bus.cmd_src_width = '0;
        bus.cmd_x         = '0;
        bus.cmd_y         = '0;
        bus.cmd_width     = '0;
        bus.cmd_height    = '0;
        bus.gen_ready     = 1'b0;
        bus.px_done       = 1'b0;
        bus.err_clear     = 1'b0;
        rst               = 1'b1;
        repeat (2) @(posedge clk); #1;

        chk1("rst_gen_valid", bus.gen_valid, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_irq", bus.irq, 1'b0);
        chk1("rst_err", bus.err, 1'b0);
        chk1("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("rst_cfg_base", bus.cfg_base_address, 32'h0);
        chk("rst_gen_width", 32'(bus.gen_width), 32'h0);
        rst = 1'b0;

        // Basic 4x2 blit
        bus.gen_ready = 1'b1;
        push(mk(32'h1000, 16'd320, 16'd2, 16'd3, 16'd4, 16'd2));
        wait_drain();
        chk("t1_cfg_base", bus.cfg_base_address, 32'h1000);
        chk("t1_cfg_pitch", 32'(bus.cfg_image_width), 32'd320);
        px(7);
        chk1("t1_irq_early", bus.irq, 1'b0);
        px(1);
        @(negedge clk);
        chk1("t1_irq", bus.irq, 1'b1);
        chk1("t1_busy", bus.busy, 1'b0);
        @(negedge clk);
        chk1("t1_irq_width", bus.irq, 1'b0);
        @(posedge clk); #1;

        // Stalled generator with a full command queue behind it
        bus.gen_ready = 1'b0;
        push(mk(32'h2000, 16'd64, 16'd10, 16'd20, 16'd2, 16'd2));
        wait_gen_valid();
        repeat (10) begin
            @(negedge clk);
            chk1("t4_hold_valid", bus.gen_valid, 1'b1);
        end
        @(posedge clk); #1;
        push(mk(32'h2100, 16'd8, 16'd1, 16'd2, 16'd2, 16'd1));
        push(mk(32'h2200, 16'd9, 16'd3, 16'd4, 16'd1, 16'd3));
        push(mk(32'h2300, 16'd10, 16'd5, 16'd6, 16'd3, 16'd1));
        push(mk(32'h2400, 16'd11, 16'd7, 16'd8, 16'd1, 16'd1));
        @(negedge clk);
        chk1("t2_full", bus.cmd_ready, 1'b0);
        @(posedge clk); #1;
        fork
            push(mk(32'h2500, 16'd12, 16'd9, 16'd10, 16'd2, 16'd2));
            begin
                repeat (3) @(posedge clk);
                #1;
                chk1("t2_still_full", bus.cmd_ready, 1'b0);
                bus.gen_ready = 1'b1;
                @(posedge clk); #1;
                chk1("t4_drain_valid", bus.gen_valid, 1'b0);
                chk1("t4_drain_busy", bus.busy, 1'b1);
                px(4);
                @(negedge clk);
                chk1("t4_irq", bus.irq, 1'b1);
                chk1("t2_full_at_irq", bus.cmd_ready, 1'b0);
            end
        join
        foreach (sz[i]) begin
            wait_drain();
            px(sz[i]);
            @(negedge clk);
            chk1("t2_irq", bus.irq, 1'b1);
            @(posedge clk); #1;
        end

        // Zero-width command is dropped, 1x1 behind it runs
        push(mk(32'h3000, 16'd16, 16'd0, 16'd0, 16'd0, 16'd5));
        push(mk(32'h4000, 16'd16, 16'd1, 16'd1, 16'd1, 16'd1));
        wait_drain();
        chk("t3_cfg_base", bus.cfg_base_address, 32'h4000);
        px(1);
        @(negedge clk);
        chk1("t3_irq", bus.irq, 1'b1);
        @(posedge clk); #1;

        // Sticky error and set-over-clear priority
        repeat (3) @(posedge clk);
        #1;
        chk1("t5_err_idle", bus.err, 1'b0);
        bus.px_done = 1'b1;
        @(posedge clk); #1;
        bus.px_done = 1'b0;
        chk1("t5_err_set", bus.err, 1'b1);
        bus.px_done   = 1'b1;
        bus.err_clear = 1'b1;
        @(posedge clk); #1;
        bus.px_done = 1'b0;
        chk1("t5_err_priority", bus.err, 1'b1);
        @(posedge clk); #1;
        bus.err_clear = 1'b0;
        chk1("t5_err_clear", bus.err, 1'b0);

        // Reset mid-drain with a command queued and err set
        bus.px_done = 1'b1;
        @(posedge clk); #1;
        bus.px_done = 1'b0;
        chk1("t6_err_pre", bus.err, 1'b1);
        push(mk(32'h5000, 16'd100, 16'd7, 16'd8, 16'd4, 16'd2));
        wait_drain();
        push(mk(32'h5100, 16'd100, 16'd0, 16'd0, 16'd1, 16'd1));
        px(3);
        rst = 1'b1;
        #1;
        chk1("t6_gen_valid", bus.gen_valid, 1'b0);
        chk1("t6_busy", bus.busy, 1'b0);
        chk1("t6_irq", bus.irq, 1'b0);
        chk1("t6_err", bus.err, 1'b0);
        chk1("t6_cmd_ready", bus.cmd_ready, 1'b1);
        chk("t6_gen_x", 32'(bus.gen_start_x), 32'h0);
        chk("t6_gen_y", 32'(bus.gen_start_y), 32'h0);
        chk("t6_gen_w", 32'(bus.gen_width), 32'h0);
        chk("t6_gen_h", 32'(bus.gen_height), 32'h0);
        chk("t6_cfg_base", bus.cfg_base_address, 32'h0);
        chk("t6_cfg_pitch", 32'(bus.cfg_image_width), 32'h0);
        gen_exp.delete();
        irq_exp.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk1("t6_queue_lost", bus.busy, 1'b0);
        push(mk(32'h6000, 16'd40, 16'd5, 16'd6, 16'd2, 16'd1));
        wait_drain();
        chk("t6_fresh_base", bus.cfg_base_address, 32'h6000);
        px(2);
        @(negedge clk);
        chk1("t6_fresh_irq", bus.irq, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("end_gen_queue", gen_exp.size(), 0);
        chk("end_irq_queue", irq_exp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
